// File: rtl/uart_byte_tx_if.sv
// Byte-transmit handshake bundle: upstream strobe/data in, serial line and status out.
interface uart_byte_tx_if;
  logic [7:0] tx_data;
  logic       in_flag;
  logic       tx;
  logic       busy;
  logic       out_flag;

  modport master (
    output tx_data,
    output in_flag,
    input  tx,
    input  busy,
    input  out_flag
  );

  modport slave (
    input  tx_data,
    input  in_flag,
    output tx,
    output busy,
    output out_flag
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 serial byte transmitter, MAX_CNT clocks per bit, busy/done handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | line high, waiting for in_flag
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first, bit_idx_q selects the slot
// S_PARITY | even parity of the latched byte (parity build only)
// S_STOP   | stop bit (high); done pulse follows on return to idle
module uart_byte_tx #(
  parameter int unsigned MAX_CNT = 5000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_byte_tx_if.slave  bus
);

  localparam logic [20:0] CNT_LAST = 21'(MAX_CNT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        out_flag_q, out_flag_d;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      out_flag_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      out_flag_q <= out_flag_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Outputs are registered, so tx_d carries the level of the slot being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    out_flag_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? 21'd0 : cnt_q + 21'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.in_flag) begin
          shift_d   = bus.tx_data;
          bit_idx_d = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^bus.tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d    = S_IDLE;
          tx_d       = 1'b1;
          busy_d     = 1'b0;
          out_flag_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.out_flag = out_flag_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: cycle-exact frames at MAX_CNT=4, loopback decode at 16.
module tb_uart_byte_tx;
  localparam int M   = 4;
  localparam int M16 = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   of4 = 0;
  int   of16 = 0;

  uart_byte_tx_if uif4 ();
  uart_byte_tx_if uif16 ();

  uart_byte_tx #(.MAX_CNT(M)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (uif4.slave)
  );

  uart_byte_tx #(.MAX_CNT(M16)) dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (uif16.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (uif4.out_flag === 1'b1) of4 <= of4 + 1;
    if (uif16.out_flag === 1'b1) of16 <= of16 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Call while idle; returns accept cycle, leaves bench in cycle a+1.
  task automatic send4(input logic [7:0] b, output int a);
    uif4.in_flag = 1'b1;
    uif4.tx_data = b;
    a = cyc;
    tick();
    uif4.in_flag = 1'b0;
    uif4.tx_data = ~b;
  endtask

  // Checks every cycle from a+1 to last; in_flag pulses with 0xFF at ign1/ign2.
  task automatic frame4(input string tag, input logic [7:0] b, input int a,
                        input int ign1, input int ign2, input int last);
    logic [7:0] dec;
    int k;
    dec = '0;
    for (int t = a + 1; t <= last; t++) begin
      if (t == ign1 || t == ign2) begin
        uif4.in_flag = 1'b1;
        uif4.tx_data = 8'hFF;
      end else begin
        uif4.in_flag = 1'b0;
      end
      @(negedge clk);
      k = (t - a - 1) / M;
      check({tag, ":tx"}, 32'(uif4.tx), 32'(exp_tx(b, k)));
      check({tag, ":busy"}, 32'(uif4.busy), 32'd1);
      check({tag, ":of_low"}, 32'(uif4.out_flag), 32'd0);
      if (k >= 1 && k <= 8 && ((t - a - 1) % M) == M / 2) dec[k-1] = uif4.tx;
      tick();
    end
    uif4.in_flag = 1'b0;
    if (last == a + NB * M) check({tag, ":decoded"}, 32'(dec), 32'(b));
  endtask

  task automatic end4(input string tag);
    @(negedge clk);
    check({tag, ":of_pulse"}, 32'(uif4.out_flag), 32'd1);
    check({tag, ":busy_end"}, 32'(uif4.busy), 32'd0);
    check({tag, ":tx_end"}, 32'(uif4.tx), 32'd1);
    tick();
  endtask

  task automatic loop16(input string tag, input logic [7:0] b);
    logic [7:0] dec;
    logic       found;
    dec = '0;
    found = 1'b0;
    uif16.in_flag = 1'b1;
    uif16.tx_data = b;
    tick();
    uif16.in_flag = 1'b0;
    uif16.tx_data = ~b;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uif16.tx === 1'b0) found = 1'b1;
    end
    check({tag, ":start_seen"}, 32'(found), 32'd1);
    if (found) begin
      repeat (M16 / 2) @(negedge clk);
      check({tag, ":start_mid"}, 32'(uif16.tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (M16) @(negedge clk);
        dec[i] = uif16.tx;
      end
      if (PAR) begin
        repeat (M16) @(negedge clk);
        check({tag, ":parity"}, 32'(uif16.tx), 32'(^b));
      end
      repeat (M16) @(negedge clk);
      check({tag, ":stop"}, 32'(uif16.tx), 32'd1);
      check({tag, ":byte"}, 32'(dec), 32'(b));
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (uif16.out_flag === 1'b1) found = 1'b1;
      end
      check({tag, ":done_seen"}, 32'(found), 32'd1);
    end
    tick();
  endtask

  initial begin
    int a, a2, p0;
    rst = 1'b1;
    uif4.in_flag = 1'b0;
    uif4.tx_data = 8'h00;
    uif16.in_flag = 1'b0;
    uif16.tx_data = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check("rst:tx", 32'(uif4.tx), 32'd1);
    check("rst:busy", 32'(uif4.busy), 32'd0);
    check("rst:of", 32'(uif4.out_flag), 32'd0);
    check("rst:tx16", 32'(uif16.tx), 32'd1);
    rst = 1'b0;
    tick();
    tick();

    // single 0x55 frame
    p0 = of4;
    send4(8'h55, a);
    frame4("t1", 8'h55, a, -1, -1, a + NB * M);
    end4("t1");
    check("t1:pulses", 32'(of4 - p0), 32'd1);
    tick();

    // back-to-back: second strobe lands in the done cycle
    p0 = of4;
    send4(8'hA5, a);
    frame4("t2a", 8'hA5, a, -1, -1, a + NB * M);
    a2 = a + NB * M + 1;
    uif4.in_flag = 1'b1;
    uif4.tx_data = 8'h3C;
    @(negedge clk);
    check("t2:of_pulse", 32'(uif4.out_flag), 32'd1);
    check("t2:busy_gap", 32'(uif4.busy), 32'd0);
    tick();
    uif4.in_flag = 1'b0;
    uif4.tx_data = 8'h00;
    frame4("t2b", 8'h3C, a2, -1, -1, a2 + NB * M);
    end4("t2b");
    check("t2:pulses", 32'(of4 - p0), 32'd2);
    tick();

    // strobes while busy are dropped
    p0 = of4;
    send4(8'h0F, a);
    frame4("t3", 8'h0F, a, a + 10, a + 25, a + NB * M);
    end4("t3");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3:busy_after", 32'(uif4.busy), 32'd0);
      check("t3:tx_after", 32'(uif4.tx), 32'd1);
      tick();
    end
    check("t3:pulses", 32'(of4 - p0), 32'd1);

    // reset mid-frame, then a clean resend
    p0 = of4;
    send4(8'h81, a);
    frame4("t4a", 8'h81, a, -1, -1, a + 17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4:tx_rst", 32'(uif4.tx), 32'd1);
    check("t4:busy_rst", 32'(uif4.busy), 32'd0);
    check("t4:of_rst", 32'(uif4.out_flag), 32'd0);
    tick();
    repeat (50) tick();
    check("t4:no_pulse", 32'(of4 - p0), 32'd0);
    check("t4:busy_idle", 32'(uif4.busy), 32'd0);
    send4(8'h81, a);
    frame4("t4b", 8'h81, a, -1, -1, a + NB * M);
    end4("t4b");
    tick();

    // 0x07 has odd weight, so the parity slot is high in the parity build
    send4(8'h07, a);
    frame4("t5", 8'h07, a, -1, -1, a + NB * M);
    end4("t5");
    tick();

    p0 = of16;
    loop16("lb00", 8'h00);
    loop16("lbFF", 8'hFF);
    loop16("lb5A", 8'h5A);
    check("lb:pulses", 32'(of16 - p0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
